// File: rtl/instr_prefetch_queue_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
// The entry type reflects the default geometry; the top builds its own from its parameters.
package fetch_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_DEPTH  = 4;
    localparam int unsigned PTR_W      = $clog2(DEF_DEPTH);

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

    // True while another read can be issued without overrunning the FIFO.
    function automatic logic has_credit(input int unsigned occ,
                                        input int unsigned infl,
                                        input int unsigned depth);
        return (occ + infl) < depth;
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 32'd1) ? $clog2(depth) : 32'd1;
    endfunction

endpackage

// File: rtl/instr_prefetch_queue_if.sv
// Redirect, memory read port and decode-side handshake of the prefetch queue.
// slave = the prefetch unit, master = its environment.
interface instr_prefetch_queue_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DEPTH  = 4
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    logic [CW-1:0]     count;
    logic              is_empty;
    logic              is_full;

    modport slave (
        input  redirect, redirect_pc, mem_rdata, instr_ready,
        output mem_rd_en, mem_addr, instr_valid, instr_out, instr_pc,
               count, is_empty, is_full
    );

    modport master (
        output redirect, redirect_pc, mem_rdata, instr_ready,
        input  mem_rd_en, mem_addr, instr_valid, instr_out, instr_pc,
               count, is_empty, is_full
    );

endinterface

// File: rtl/instr_prefetch_queue_sync_fifo.sv
// Synchronous FIFO with single-cycle flush; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned WIDTH = 43,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = ptr_width(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualified push/pop and status flags.
    always_comb begin
        empty     = (count_r == CW'(0));
        full      = (count_r == CW'(DEPTH));
        push_ok_s = push & ~full & ~flush;
        pop_ok_s  = pop & ~empty & ~flush;
        rdata     = mem_r[rd_ptr_r];
        count     = count_r;
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Credit-based sequential instruction prefetcher with PC-tagged FIFO,
// empty-queue bypass of the memory response and one-cycle redirect flush.
module instr_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       ADDR_W   = 11,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter bit                BYPASS   = 1'b1
) (
    input logic                    clk,
    input logic                    rst_n,
    instr_prefetch_queue_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic [ADDR_W-1:0] fetch_pc_r;
    logic [ADDR_W-1:0] inflight_pc_r;
    logic              inflight_r;
    entry_t            push_entry_s;
    entry_t            head_entry_s;
    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_empty_s;
    logic              fifo_full_s;
    logic [CW-1:0]     fifo_count_s;
    logic              issue_s;
    logic              bypass_s;
    logic              valid_s;
    logic              pop_s;

    // Issue credit, bypass selection and FIFO push/pop decisions.
    always_comb begin
        issue_s      = rst_n & ~bus.redirect &
                       has_credit(32'(fifo_count_s), 32'(inflight_r), DEPTH);
        bypass_s     = BYPASS & fifo_empty_s & inflight_r;
        valid_s      = ~fifo_empty_s | bypass_s;
        pop_s        = valid_s & bus.instr_ready & ~bus.redirect;
        fifo_pop_s   = pop_s & ~fifo_empty_s;
        // A bypassed word that the consumer takes never enters the FIFO.
        fifo_push_s  = inflight_r & ~bus.redirect & ~(bypass_s & bus.instr_ready);
        push_entry_s = '{instr: bus.mem_rdata, pc: inflight_pc_r};
    end

    // Output selection: FIFO head first, then the raw response, else idle zeros.
    always_comb begin
        if (!fifo_empty_s) begin
            bus.instr_out = head_entry_s.instr;
            bus.instr_pc  = head_entry_s.pc;
        end else if (bypass_s) begin
            bus.instr_out = bus.mem_rdata;
            bus.instr_pc  = inflight_pc_r;
        end else begin
            bus.instr_out = '0;
            bus.instr_pc  = '0;
        end
        bus.instr_valid = valid_s;
        bus.mem_rd_en   = issue_s;
        bus.mem_addr    = fetch_pc_r;
        bus.count       = fifo_count_s;
        bus.is_empty    = fifo_empty_s;
        bus.is_full     = fifo_full_s;
    end

    // Fetch PC and in-flight read tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            inflight_r    <= 1'b0;
            inflight_pc_r <= '0;
        end else if (bus.redirect) begin
            fetch_pc_r <= bus.redirect_pc;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                inflight_pc_r <= fetch_pc_r;
                fetch_pc_r    <= fetch_pc_r + ADDR_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect),
        .push  (fifo_push_s),
        .pop   (fifo_pop_s),
        .wdata (push_entry_s),
        .rdata (head_entry_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s),
        .full  (fifo_full_s)
    );

    fetch_credit_chk #(
        .DEPTH (DEPTH)
    ) u_chk (
        .clk      (clk),
        .rst_n    (rst_n),
        .count    (fifo_count_s),
        .inflight (inflight_r),
        .push     (fifo_push_s),
        .full     (fifo_full_s)
    );

endmodule

// Simulation checks on the issue-credit invariant.
module fetch_credit_chk #(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          inflight,
    input logic          push,
    input logic          full
);

    credit_a: assert property (@(posedge clk) disable iff (!rst_n)
        (32'(count) + 32'(inflight)) <= DEPTH)
        else $error("prefetch credit overflow: count %0d inflight %0d", count, inflight);

    push_full_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full))
        else $error("prefetch push into full queue");

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue with a 1-cycle registered memory model
// returning 32'hA000_0000 | address.
module tb_instr_prefetch_queue;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    instr_prefetch_queue_if #(.DATA_W(32), .ADDR_W(11), .DEPTH(4)) bus ();

    instr_prefetch_queue #(
        .DATA_W(32), .ADDR_W(11), .DEPTH(4), .RESET_PC(11'h000), .BYPASS(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= 32'hA000_0000 | {21'd0, bus.mem_addr};
    end

    function automatic logic [31:0] mem_word(input logic [10:0] a);
        return 32'hA000_0000 | {21'd0, a};
    endfunction

    task automatic do_reset(input logic rv);
        @(negedge clk);
        rst_n = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 11'h000; bus.instr_ready = rv;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 11'h000; bus.instr_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", bus.mem_rd_en); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.instr_valid); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.is_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.is_empty); end
        checks++; if (bus.instr_out !== 32'h0 || bus.instr_pc !== 11'h0) begin errors++; $display("FAIL reset_out got %h/%h want 0/0", bus.instr_out, bus.instr_pc); end
        checks++; if (bus.mem_addr !== 11'h000) begin errors++; $display("FAIL reset_addr got %h want 000", bus.mem_addr); end
    endtask

    task automatic test_stream;
        logic [10:0] e;
        do_reset(1'b1);
        checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 11'h000) begin errors++; $display("FAIL stream_first_issue got %b/%h want 1/000", bus.mem_rd_en, bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got %b want 0", bus.instr_valid); end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = 11'(k);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr_out !== mem_word(e) || bus.count !== 3'd0) begin
                errors++; $display("FAIL stream[%0d] got v%b %h/%h c%0d want v1 %h/%h c0", k, bus.instr_valid, bus.instr_out, bus.instr_pc, bus.count, mem_word(e), e);
            end
        end
    endtask

    task automatic test_full_drain;
        int reads = 0;
        logic [10:0] e;
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (bus.mem_rd_en) reads++;
            @(negedge clk);
        end
        checks++; if (reads != 4) begin errors++; $display("FAIL full_reads got %0d want 4", reads); end
        checks++; if (bus.count !== 3'd4 || bus.is_full !== 1'b1) begin errors++; $display("FAIL full_count got %0d/%b want 4/1", bus.count, bus.is_full); end
        checks++; if (bus.mem_rd_en !== 1'b0 || bus.mem_addr !== 11'h004) begin errors++; $display("FAIL full_hold got %b/%h want 0/004", bus.mem_rd_en, bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 11'h000) begin errors++; $display("FAIL full_head got %b/%h want 1/000", bus.instr_valid, bus.instr_pc); end
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            #1;
            e = 11'(k);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr_out !== mem_word(e)) begin
                errors++; $display("FAIL drain[%0d] got v%b %h/%h want v1 %h/%h", k, bus.instr_valid, bus.instr_out, bus.instr_pc, mem_word(e), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect_full;
        logic [10:0] e;
        do_reset(1'b0);
        repeat (6) @(negedge clk);
        checks++; if (bus.is_full !== 1'b1) begin errors++; $display("FAIL redir_pre_full got %b want 1", bus.is_full); end
        bus.redirect = 1'b1; bus.redirect_pc = 11'h040;
        #1;
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL redir_no_issue got %b want 0", bus.mem_rd_en); end
        @(negedge clk);
        bus.redirect = 1'b0; bus.redirect_pc = 11'h000; bus.instr_ready = 1'b1;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush got c%0d v%b want c0 v0", bus.count, bus.instr_valid); end
        checks++; if (bus.mem_addr !== 11'h040 || bus.mem_rd_en !== 1'b1) begin errors++; $display("FAIL redir_addr got %h/%b want 040/1", bus.mem_addr, bus.mem_rd_en); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            e = 11'h040 + 11'(k);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== e || bus.instr_out !== mem_word(e)) begin
                errors++; $display("FAIL redir_out[%0d] got v%b %h/%h want v1 %h/%h", k, bus.instr_valid, bus.instr_out, bus.instr_pc, mem_word(e), e);
            end
        end
    endtask

    task automatic test_redirect_busy;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 11'h002) begin errors++; $display("FAIL busy_pre got %b/%h want 1/002", bus.instr_valid, bus.instr_pc); end
        bus.redirect = 1'b1; bus.redirect_pc = 11'h100;
        #1;
        checks++; if (bus.mem_rd_en !== 1'b0) begin errors++; $display("FAIL busy_no_issue got %b want 0", bus.mem_rd_en); end
        @(negedge clk);
        bus.redirect = 1'b0;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.instr_valid !== 1'b0 || bus.is_empty !== 1'b1) begin errors++; $display("FAIL busy_flush got c%0d v%b e%b want c0 v0 e1", bus.count, bus.instr_valid, bus.is_empty); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 11'h100 || bus.instr_out !== 32'hA000_0100) begin errors++; $display("FAIL busy_target got v%b %h/%h want v1 a0000100/100", bus.instr_valid, bus.instr_out, bus.instr_pc); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 11'h101 || bus.instr_out !== 32'hA000_0101) begin errors++; $display("FAIL busy_next got v%b %h/%h want v1 a0000101/101", bus.instr_valid, bus.instr_out, bus.instr_pc); end
    endtask

    task automatic test_wrap;
        logic [10:0] pcs  [4];
        logic [31:0] data [4];
        pcs  = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        data = '{32'hA000_07FE, 32'hA000_07FF, 32'hA000_0000, 32'hA000_0001};
        bus.instr_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 11'h7FE;
        @(negedge clk);
        bus.redirect = 1'b0; bus.redirect_pc = 11'h000;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== pcs[k] || bus.instr_out !== data[k]) begin
                errors++; $display("FAIL wrap[%0d] got v%b %h/%h want v1 %h/%h", k, bus.instr_valid, bus.instr_out, bus.instr_pc, data[k], pcs[k]);
            end
        end
    endtask

    task automatic test_async_reset;
        do_reset(1'b0);
        repeat (6) @(negedge clk);
        checks++; if (bus.count !== 3'd4 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL areset_pre got c%0d v%b want c4 v1", bus.count, bus.instr_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.instr_valid !== 1'b0 || bus.count !== 3'd0 || bus.mem_rd_en !== 1'b0 || bus.is_empty !== 1'b1) begin
            errors++; $display("FAIL areset_clear got v%b c%0d rd%b e%b want v0 c0 rd0 e1", bus.instr_valid, bus.count, bus.mem_rd_en, bus.is_empty);
        end
        @(negedge clk);
        bus.instr_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 11'h000 || bus.instr_out !== 32'hA000_0000) begin errors++; $display("FAIL areset_first got v%b %h/%h want v1 a0000000/000", bus.instr_valid, bus.instr_out, bus.instr_pc); end
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 11'h001 || bus.instr_out !== 32'hA000_0001) begin errors++; $display("FAIL areset_second got v%b %h/%h want v1 a0000001/001", bus.instr_valid, bus.instr_out, bus.instr_pc); end
    endtask

    initial begin
        bus.mem_rdata = 32'h0;
        test_reset();
        test_stream();
        test_full_drain();
        test_redirect_full();
        test_redirect_busy();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
